// File: rtl/garage_lane_arbiter.sv
// garage_lane_arbiter: one gate/ticket resource shared by the entry and exit lanes.
// Optional grant watchdog enabled by defining GRANT_TIMEOUT_EN.
module garage_lane_arbiter #(
   parameter int CAPACITY   = 64,
   parameter int CNT_W      = 7,
   parameter int TIMEOUT_MS = 30000,
   parameter int TMR_W      = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             entry_req,
   input  logic             exit_req,
   input  logic             entry_done,
   input  logic             exit_done,
   input  logic             entry_abort,
   input  logic             exit_abort,
   input  logic             out_of_service,
   input  logic             tick_1ms,
   output logic             entry_grant,
   output logic             exit_grant,
   output logic [CNT_W-1:0] occupancy,
   output logic             garage_full,
   output logic             garage_empty,
   output logic             timeout_err
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_GRANT_ENTRY,
      S_GRANT_EXIT,
      S_RELEASE
   } state_t;

   typedef enum logic {
      LANE_ENTRY,
      LANE_EXIT
   } lane_t;

   localparam logic [CNT_W-1:0] CAP = CNT_W'(CAPACITY);

   state_t           state;
   state_t           state_nxt;
   lane_t            last_served;
   lane_t            last_nxt;
   logic [CNT_W-1:0] occ_nxt;
   logic             tmo_nxt;
   logic             ent_ok;
   logic             ext_ok;

`ifdef GRANT_TIMEOUT_EN
   localparam logic [TMR_W-1:0] TMO_LIM = TMR_W'(TIMEOUT_MS);
   logic [TMR_W-1:0] tmr;
   logic [TMR_W-1:0] tmr_nxt;
`else
   logic [TMR_W:0] unused_cfg;
   assign unused_cfg = {tick_1ms, TMR_W'(TIMEOUT_MS)};
`endif

   // Next-state, occupancy and service bookkeeping.
   always_comb begin
      state_nxt = state;
      last_nxt  = last_served;
      occ_nxt   = occupancy;
      tmo_nxt   = 1'b0;
      ent_ok    = entry_req & ~garage_full & ~out_of_service;
      ext_ok    = exit_req & ~garage_empty & ~out_of_service;
`ifdef GRANT_TIMEOUT_EN
      tmr_nxt   = tmr;
`endif
      case (state)
         S_IDLE: begin
`ifdef GRANT_TIMEOUT_EN
            tmr_nxt = '0;
`endif
            if (ent_ok && ext_ok) begin
               if (last_served == LANE_ENTRY)
                  state_nxt = S_GRANT_EXIT;
               else
                  state_nxt = S_GRANT_ENTRY;
            end else if (ent_ok) begin
               state_nxt = S_GRANT_ENTRY;
            end else if (ext_ok) begin
               state_nxt = S_GRANT_EXIT;
            end
         end
         S_GRANT_ENTRY: begin
            if (entry_done) begin
               if (occupancy != CAP)
                  occ_nxt = occupancy + CNT_W'(1);
               last_nxt  = LANE_ENTRY;
               state_nxt = S_RELEASE;
            end else if (entry_abort) begin
               last_nxt  = LANE_ENTRY;
               state_nxt = S_RELEASE;
`ifdef GRANT_TIMEOUT_EN
            end else if (tick_1ms) begin
               if (tmr == TMO_LIM - TMR_W'(1)) begin
                  tmo_nxt   = 1'b1;
                  last_nxt  = LANE_ENTRY;
                  state_nxt = S_RELEASE;
               end else begin
                  tmr_nxt = tmr + TMR_W'(1);
               end
`endif
            end
         end
         S_GRANT_EXIT: begin
            if (exit_done) begin
               if (occupancy != '0)
                  occ_nxt = occupancy - CNT_W'(1);
               last_nxt  = LANE_EXIT;
               state_nxt = S_RELEASE;
            end else if (exit_abort) begin
               last_nxt  = LANE_EXIT;
               state_nxt = S_RELEASE;
`ifdef GRANT_TIMEOUT_EN
            end else if (tick_1ms) begin
               if (tmr == TMO_LIM - TMR_W'(1)) begin
                  tmo_nxt   = 1'b1;
                  last_nxt  = LANE_EXIT;
                  state_nxt = S_RELEASE;
               end else begin
                  tmr_nxt = tmr + TMR_W'(1);
               end
`endif
            end
         end
         S_RELEASE: state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   // State and registered outputs; flags track the new occupancy on the same edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= S_IDLE;
         last_served  <= LANE_ENTRY;
         occupancy    <= '0;
         entry_grant  <= 1'b0;
         exit_grant   <= 1'b0;
         garage_full  <= 1'b0;
         garage_empty <= 1'b1;
         timeout_err  <= 1'b0;
      end else begin
         state        <= state_nxt;
         last_served  <= last_nxt;
         occupancy    <= occ_nxt;
         entry_grant  <= (state_nxt == S_GRANT_ENTRY);
         exit_grant   <= (state_nxt == S_GRANT_EXIT);
         garage_full  <= (occ_nxt == CAP);
         garage_empty <= (occ_nxt == '0);
         timeout_err  <= tmo_nxt;
      end
   end

`ifdef GRANT_TIMEOUT_EN
   // Watchdog counter of tick_1ms pulses while a grant is held.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         tmr <= '0;
      else
         tmr <= tmr_nxt;
   end
`endif

endmodule

// File: tb/tb_garage_lane_arbiter.sv
// tb_garage_lane_arbiter: directed scenarios plus random traffic
// checked against a service-level model of the garage.
module tb_garage_lane_arbiter;

   localparam int CAP = 4;
   localparam int TMO = 5;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       entry_req = 1'b0;
   logic       exit_req = 1'b0;
   logic       entry_done = 1'b0;
   logic       exit_done = 1'b0;
   logic       entry_abort = 1'b0;
   logic       exit_abort = 1'b0;
   logic       out_of_service = 1'b0;
   logic       tick_1ms = 1'b0;
   logic       entry_grant;
   logic       exit_grant;
   logic [2:0] occupancy;
   logic       garage_full;
   logic       garage_empty;
   logic       timeout_err;

   int n_assert = 0;
   int n_fail = 0;

   // model: cars inside, current owner (0 none/1 entry/2 exit),
   // pending release cycle, last lane served, ticks during grant
   int m_occ;
   int m_own;
   int m_gap;
   int m_last;
   int m_tk;
   int m_tmo;

   garage_lane_arbiter #(
      .CAPACITY(CAP),
      .CNT_W(3),
      .TIMEOUT_MS(TMO),
      .TMR_W(4)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .entry_req(entry_req),
      .exit_req(exit_req),
      .entry_done(entry_done),
      .exit_done(exit_done),
      .entry_abort(entry_abort),
      .exit_abort(exit_abort),
      .out_of_service(out_of_service),
      .tick_1ms(tick_1ms),
      .entry_grant(entry_grant),
      .exit_grant(exit_grant),
      .occupancy(occupancy),
      .garage_full(garage_full),
      .garage_empty(garage_empty),
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_occ = 0;
      m_own = 0;
      m_gap = 0;
      m_last = 1;
      m_tk = 0;
      m_tmo = 0;
   endtask

   task automatic end_service();
      m_last = m_own;
      m_own = 0;
      m_gap = 1;
   endtask

   task automatic model_step();
      bit e;
      bit x;
      bit d;
      bit a;
      m_tmo = 0;
      if (m_gap != 0) begin
         m_gap = 0;
      end else if (m_own == 0) begin
         e = entry_req && m_occ < CAP && !out_of_service;
         x = exit_req && m_occ > 0 && !out_of_service;
         m_tk = 0;
         if (e && x) m_own = (m_last == 1) ? 2 : 1;
         else if (e) m_own = 1;
         else if (x) m_own = 2;
      end else begin
         d = (m_own == 1) ? entry_done : exit_done;
         a = (m_own == 1) ? entry_abort : exit_abort;
         if (d) begin
            if (m_own == 1 && m_occ < CAP) m_occ++;
            if (m_own == 2 && m_occ > 0) m_occ--;
            end_service();
         end else if (a) begin
            end_service();
         end else if (tick_1ms) begin
`ifdef GRANT_TIMEOUT_EN
            m_tk++;
            if (m_tk == TMO) begin
               m_tmo = 1;
               end_service();
            end
`endif
         end
      end
   endtask

   task automatic check_all();
      chk("entry_grant", 32'(entry_grant), 32'(m_own == 1));
      chk("exit_grant", 32'(exit_grant), 32'(m_own == 2));
      chk("occupancy", 32'(occupancy), 32'(m_occ));
      chk("garage_full", 32'(garage_full), 32'(m_occ == CAP));
      chk("garage_empty", 32'(garage_empty), 32'(m_occ == 0));
      chk("timeout_err", 32'(timeout_err), 32'(m_tmo));
      chk("both_grants", 32'(entry_grant & exit_grant), 32'd0);
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      #1;
      check_all();
   endtask

   task automatic wait_grant(output int lane, output int n);
      lane = 0;
      n = 0;
      while (lane == 0 && n < 20) begin
         cyc();
         n++;
         if (entry_grant) lane = 1;
         else if (exit_grant) lane = 2;
      end
      if (lane == 0) chk("grant_wait_expired", 32'd0, 32'd1);
   endtask

   task automatic pulse_done(input int lane);
      if (lane == 1) entry_done = 1'b1;
      else exit_done = 1'b1;
      cyc();
      entry_done = 1'b0;
      exit_done = 1'b0;
   endtask

   task automatic serve(input int lane);
      int g;
      int n;
      if (lane == 1) entry_req = 1'b1;
      else exit_req = 1'b1;
      wait_grant(g, n);
      entry_req = 1'b0;
      exit_req = 1'b0;
      pulse_done(lane);
   endtask

   initial begin
      int g;
      int n;
      int order[4];
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all();
      reset_n = 1'b1;

      // 1: single entry
      entry_req = 1'b1;
      cyc();
      chk("t1_grant", 32'(entry_grant), 32'd1);
      entry_req = 1'b0;
      pulse_done(1);
      chk("t1_occ", 32'(occupancy), 32'd1);
      chk("t1_empty", 32'(garage_empty), 32'd0);

      // 2: exit blocked when empty
      serve(2);
      exit_req = 1'b1;
      repeat (100) cyc();
      chk("t2_no_exit", 32'(exit_grant), 32'd0);
      exit_req = 1'b0;

      // 3: alternation with both lanes requesting
      serve(1);
      serve(1);
      entry_req = 1'b1;
      exit_req = 1'b1;
      for (int k = 0; k < 4; k++) begin
         wait_grant(g, n);
         order[k] = g;
         if (k > 0) chk("t3_gap", 32'(n), 32'd2);
         pulse_done(g);
      end
      entry_req = 1'b0;
      exit_req = 1'b0;
      chk("t3_order0", 32'(order[0]), 32'd2);
      chk("t3_order1", 32'(order[1]), 32'd1);
      chk("t3_order2", 32'(order[2]), 32'd2);
      chk("t3_order3", 32'(order[3]), 32'd1);

      // 4: full garage blocks entry
      serve(1);
      serve(1);
      chk("t4_full", 32'(garage_full), 32'd1);
      entry_req = 1'b1;
      repeat (10) cyc();
      chk("t4_blocked", 32'(entry_grant), 32'd0);
      exit_req = 1'b1;
      wait_grant(g, n);
      chk("t4_exit_lane", 32'(g), 32'd2);
      exit_req = 1'b0;
      pulse_done(2);
      chk("t4_occ", 32'(occupancy), 32'd3);
      chk("t4_not_full", 32'(garage_full), 32'd0);
      cyc();
      chk("t4_release", 32'(entry_grant), 32'd0);
      cyc();
      chk("t4_regrant", 32'(entry_grant), 32'd1);
      entry_req = 1'b0;
      pulse_done(1);

      // 5: abort, done+abort, foreign done, reset mid-grant
      serve(2);
      entry_req = 1'b1;
      wait_grant(g, n);
      entry_req = 1'b0;
      entry_abort = 1'b1;
      cyc();
      entry_abort = 1'b0;
      chk("t5_abort_occ", 32'(occupancy), 32'd3);
      entry_req = 1'b1;
      wait_grant(g, n);
      entry_req = 1'b0;
      exit_done = 1'b1;
      cyc();
      exit_done = 1'b0;
      chk("t5_foreign_grant", 32'(entry_grant), 32'd1);
      chk("t5_foreign_occ", 32'(occupancy), 32'd3);
      entry_done = 1'b1;
      entry_abort = 1'b1;
      cyc();
      entry_done = 1'b0;
      entry_abort = 1'b0;
      chk("t5_done_wins", 32'(occupancy), 32'd4);
      exit_req = 1'b1;
      wait_grant(g, n);
      chk("t5_exit_grant", 32'(exit_grant), 32'd1);
      reset_n = 1'b0;
      #1;
      model_reset();
      chk("t5_rst_grant", 32'(exit_grant), 32'd0);
      chk("t5_rst_occ", 32'(occupancy), 32'd0);
      check_all();
      exit_req = 1'b0;
      @(posedge clk);
      #1;
      reset_n = 1'b1;

      // 6: watchdog
      serve(1);
      entry_req = 1'b1;
      wait_grant(g, n);
      entry_req = 1'b0;
`ifdef GRANT_TIMEOUT_EN
      for (int i = 0; i < TMO; i++) begin
         tick_1ms = 1'b1;
         cyc();
         tick_1ms = 1'b0;
         if (i < TMO - 1) cyc();
      end
      chk("t6_revoked", 32'(entry_grant), 32'd0);
      chk("t6_tmo_pulse", 32'(timeout_err), 32'd1);
      chk("t6_occ", 32'(occupancy), 32'd1);
      cyc();
      chk("t6_tmo_clear", 32'(timeout_err), 32'd0);
`else
      for (int i = 0; i < 50; i++) begin
         tick_1ms = 1'b1;
         cyc();
         tick_1ms = 1'b0;
      end
      chk("t6_held", 32'(entry_grant), 32'd1);
      chk("t6_no_tmo", 32'(timeout_err), 32'd0);
      pulse_done(1);
`endif

      // random traffic
      for (int i = 0; i < 1500; i++) begin
         entry_req = ($urandom_range(99) < 55);
         exit_req = ($urandom_range(99) < 50);
         entry_done = ($urandom_range(99) < 25);
         exit_done = ($urandom_range(99) < 25);
         entry_abort = ($urandom_range(99) < 8);
         exit_abort = ($urandom_range(99) < 8);
         out_of_service = ($urandom_range(99) < 5);
         tick_1ms = ($urandom_range(99) < 40);
         cyc();
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
